// File: rtl/shift_pkg.sv
// Shared opcode and state definitions for the shift sequencer.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_ASL = 3'b000,
    OP_ASR = 3'b001,
    OP_LSL = 3'b010,
    OP_LSR = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101,
    OP_RSV = 3'b110
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_e;

  // Both 110 and 111 are reserved; only 110 gets a name.
  function automatic logic isReserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit combinational shift/rotate step with carry-out.
module shift_step
  import shift_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic [NBITS-1:0] value,
  input  logic [2:0]       op,
  output logic [NBITS-1:0] result,
  output logic             carry
);

  always_comb begin
    result = value;
    carry  = 1'b0;
    case (op)
      OP_ASL, OP_LSL: begin
        result = {value[NBITS-2:0], 1'b0};
        carry  = value[NBITS-1];
      end
      OP_ASR: begin
        result = {value[NBITS-1], value[NBITS-1:1]};
        carry  = value[0];
      end
      OP_LSR: begin
        result = {1'b0, value[NBITS-1:1]};
        carry  = value[0];
      end
      OP_ROL: begin
        result = {value[NBITS-2:0], value[NBITS-1]};
        carry  = value[NBITS-1];
      end
      OP_ROR: begin
        result = {value[0], value[NBITS-1:1]};
        carry  = value[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: IDLE -> RUN (one step per cycle) -> DONE.
// Optional STICKY accumulator enabled by macro SHIFT_SEQ_STICKY_EN.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int NBITS = 4,
  parameter int CNTW  = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [NBITS-1:0] A,
  input  logic [2:0]       OpCode,
  input  logic [CNTW-1:0]  COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [NBITS-1:0] Q,
  output logic             C,
  output logic             STICKY
);

  seq_state_e        state, stateNext;
  logic [2:0]        opReg;
  logic [CNTW-1:0]   cntReg;
  logic [NBITS-1:0]  stepResult;
  logic              stepCarry;
  logic              stepEn;

  shift_step #(.NBITS(NBITS)) uStep (
    .value  (Q),
    .op     (opReg),
    .result (stepResult),
    .carry  (stepCarry)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    stepEn    = 1'b0;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) stateNext = S_RUN;
      end
      S_RUN: begin
        if (isReserved(opReg) || (cntReg == '0)) stateNext = S_DONE;
        else                                     stepEn    = 1'b1;
      end
      S_DONE: begin
        DONE      = 1'b1;
        stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q      <= '0;
      C      <= 1'b0;
      opReg  <= '0;
      cntReg <= '0;
    end else if ((state == S_IDLE) && START) begin
      Q      <= A;
      C      <= 1'b0;
      opReg  <= OpCode;
      cntReg <= COUNT;
    end else if ((state == S_RUN) && isReserved(opReg)) begin
      Q <= '0;
      C <= 1'b0;
    end else if (stepEn) begin
      Q      <= stepResult;
      C      <= stepCarry;
      cntReg <= cntReg - 1'b1;
    end
  end

`ifdef SHIFT_SEQ_STICKY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                         STICKY <= 1'b0;
    else if ((state == S_IDLE) && START) STICKY <= 1'b0;
    else if (stepEn)                    STICKY <= STICKY | stepCarry;
  end
`else
  assign STICKY = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

  localparam int NBITS = 4;
  localparam int CNTW  = 3;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             START;
  logic [NBITS-1:0] A;
  logic [2:0]       OpCode;
  logic [CNTW-1:0]  COUNT;
  logic             BUSY, DONE, C, STICKY;
  logic [NBITS-1:0] Q;

  int totalChecks = 0;
  int failChecks  = 0;

  shift_sequencer #(.NBITS(NBITS), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .OpCode(OpCode),
    .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE), .Q(Q), .C(C), .STICKY(STICKY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) else begin
      failChecks++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result computed with plain integer arithmetic; lat is the number
  // of edges after the accept edge before DONE becomes visible.
  function automatic void model(input int a, input int op, input int cnt,
                                output int q, output int c, output int s, output int lat);
    int mask, msb;
    mask = (1 << NBITS) - 1;
    msb  = 1 << (NBITS - 1);
    q = a; c = 0; s = 0;
    if (op >= 6) begin
      q = 0; lat = 1;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      case (op)
        0, 2: begin c = (q >> (NBITS-1)) & 1; q = (q * 2) & mask; end
        1:    begin c = q & 1; q = (q / 2) | (q & msb); end
        3:    begin c = q & 1; q = q / 2; end
        4:    begin c = (q >> (NBITS-1)) & 1; q = ((q * 2) + c) & mask; end
        default: begin c = q & 1; q = (q / 2) + c * msb; end
      endcase
      s = s | c;
    end
    lat = cnt + 1;
  endfunction

  // Called at a negedge; returns at the negedge of the idle cycle after DONE,
  // so consecutive calls exercise back-to-back starts.
  task automatic runSeq(input string tag, input int a, input int op, input int cnt);
    int eq, ec, es, elat, seen;
    model(a, op, cnt, eq, ec, es, elat);
`ifndef SHIFT_SEQ_STICKY_EN
    es = 0;
`endif
    START = 1'b1; A = a[NBITS-1:0]; OpCode = op[2:0]; COUNT = cnt[CNTW-1:0];
    @(posedge CLK);
    seen = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        check({tag, "_busy"}, BUSY, 1);
        // Probe: a START while busy with different operands must be ignored.
        START = 1'b1; A = ~a[NBITS-1:0]; OpCode = 3'b011; COUNT = 3'd7;
      end else begin
        START = 1'b0;
      end
      if (DONE === 1'b1) begin
        seen = i;
        break;
      end
    end
    START = 1'b0;
    if (seen < 0) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, seen, elat);
      check({tag, "_q"}, Q, eq);
      check({tag, "_c"}, C, ec);
      check({tag, "_sticky"}, STICKY, es);
      @(negedge CLK);
      check({tag, "_done_pulse"}, {DONE, BUSY}, 2'b00);
      check({tag, "_q_hold"}, Q, eq);
    end
  endtask

  initial begin
    int dCount;
    RST_N = 1'b0; START = 1'b0; A = '0; OpCode = '0; COUNT = '0;
    repeat (2) @(negedge CLK);
    check("reset_outs", {Q, C, STICKY, BUSY, DONE}, '0);
    RST_N = 1'b1;
    @(negedge CLK);

    runSeq("lsl2",  4'b1011, 3'b010, 2);
    runSeq("ror1",  4'b1011, 3'b101, 1);
    runSeq("asr3",  4'b1000, 3'b001, 3);
    runSeq("cnt0",  4'b0110, 3'b000, 0);
    runSeq("rsv7",  4'b0110, 3'b111, 5);
    runSeq("rsv6",  4'b1111, 3'b110, 1);

    // Abort mid-RUN with reset: no DONE, all outputs zero, then restart.
    START = 1'b1; A = 4'b1001; OpCode = 3'b100; COUNT = 3'd7;
    @(posedge CLK);
    @(negedge CLK); START = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("abort_outs", {Q, C, STICKY, BUSY, DONE}, '0);
    @(negedge CLK);
    RST_N = 1'b1;
    dCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) dCount++;
    end
    check("abort_no_done", dCount, 0);
    check("abort_idle", BUSY, 0);
    runSeq("post_rst", 4'b1001, 3'b100, 7);

    for (int n = 0; n < 24; n++) begin
      int a, op, cnt;
      a   = $urandom_range(0, (1 << NBITS) - 1);
      op  = $urandom_range(0, 7);
      cnt = $urandom_range(0, (1 << CNTW) - 1);
      if (op >= 6 && cnt == 0) cnt = 1;
      runSeq($sformatf("rnd%0d", n), a, op, cnt);
    end

    $display("%0d/%0d checks passed", totalChecks - failChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter NBITS, default 4, giving the data width (minimum 2).
REQ-002 The block SHALL have parameter CNTW, default 3, giving the shift-count width (maximum count 2^CNTW-1).
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit, the reset; asynchronous assert and active-low.
REQ-005 The block SHALL have port START, input, 1 bit, the request to begin a sequence.
REQ-006 The block SHALL have port A, input, NBITS bits, the operand, sampled when START is accepted.
REQ-007 The block SHALL have port OpCode, input, 3 bits, the shift operation, sampled when START is accepted.
REQ-008 The block SHALL have port COUNT, input, CNTW bits, the number of single-bit steps, sampled when START is accepted.
REQ-009 The block SHALL have port BUSY, output, 1 bit, high while a sequence is in progress.
REQ-010 The block SHALL have port DONE, output, 1 bit, a one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port Q, output, NBITS bits, the result register.
REQ-012 The block SHALL have port C, output, 1 bit, the last bit shifted out.
REQ-013 The block SHALL have port STICKY, output, 1 bit, the OR of all bits shifted out (see Configuration).

Function
REQ-014 The block SHALL implement the state machine IDLE -> RUN -> DONE -> IDLE.
REQ-015 In IDLE with START=1, the block SHALL load A into Q, load OpCode and COUNT into internal registers, clear C and STICKY, and go to RUN.
REQ-016 In RUN, each cycle SHALL apply one step to Q, update C from that step, and decrement the remaining count; when the remaining count is 0, the block SHALL go to DONE instead of stepping.
REQ-017 The step operations SHALL be: 000 arithmetic left, carry = Q[NBITS-1]; 001 arithmetic right (sign bit kept), carry = Q[0]; 010 logical left, carry = Q[NBITS-1]; 011 logical right, carry = Q[0]; 100 rotate left, carry = Q[NBITS-1]; 101 rotate right, carry = Q[0].
REQ-018 For OpCode 110 or 111, the block SHALL skip stepping, force Q=0 and C=0 on the first RUN cycle, and go to DONE.
REQ-019 With COUNT=0, the block SHALL leave Q equal to A and C equal to 0, and assert DONE 2 cycles after START is accepted.
REQ-020 In general, DONE SHALL assert COUNT+2 cycles after the START-accept edge and remain high for exactly one cycle, in state DONE.
REQ-021 BUSY SHALL be 1 in RUN and DONE and 0 in IDLE; START SHALL be ignored while BUSY=1.
REQ-022 Q, C and STICKY SHALL hold their values from DONE until the next accepted START.
REQ-023 A START asserted in the cycle after DONE SHALL be accepted normally, so back-to-back sequences have no dead cycle beyond IDLE.

Reset
REQ-024 When RST_N=0, the block SHALL asynchronously set the state to IDLE, and set Q=0, C=0, STICKY=0, BUSY=0, DONE=0, and the count and opcode registers to 0.
REQ-025 A reset during RUN SHALL abort the sequence with no DONE pulse; the first START after RST_N rises SHALL be accepted on the next edge.

Configuration
REQ-026 With macro SHIFT_SEQ_STICKY_EN defined, STICKY SHALL be OR-accumulated with each step's carry.
REQ-027 With SHIFT_SEQ_STICKY_EN undefined, STICKY SHALL be driven constant 0, the port SHALL remain present, and no accumulator flop SHALL exist.

Structure
REQ-028 The opcode encodings (6 operations plus the reserved value) and the state encoding typedef SHALL live in shared package shift_pkg.
REQ-029 The single-step combinational shift and carry SHALL be in sub-module shift_step (inputs: value, op; outputs: result, carry), instantiated once.

Verification (NBITS=4, CNTW=3, SHIFT_SEQ_STICKY_EN defined)
REQ-030 The bench SHALL drive A=1011, OpCode=010, COUNT=2 and check Q=1100, C=0, STICKY=1, with DONE at cycle 4.
REQ-031 The bench SHALL drive A=1011, OpCode=101, COUNT=1 and check Q=1101, C=1.
REQ-032 The bench SHALL drive A=1000, OpCode=001, COUNT=3 and check Q=1111, C=0, STICKY=0.
REQ-033 The bench SHALL drive A=0110, COUNT=0 (any valid op) and check Q=0110, C=0, with DONE at cycle 2; then drive OpCode=111 and check Q=0000, C=0.
REQ-034 The bench SHALL pulse RST_N low in mid-RUN of COUNT=7 and check all outputs are 0, no DONE occurs, and a following START completes correctly.
REQ-035 The bench SHALL re-assert START while BUSY=1 and check it is ignored, and SHALL start a new sequence in the cycle after DONE and check it is accepted.
